// File: rtl/alu_pkg.sv
// Shared ALU-64 definitions: iteration counter width, FSM state encoding and
// direction constants.
package alu_pkg;

  localparam int ITER_W = 6;

  typedef enum logic [1:0] {
    ITER_IDLE = 2'd0,
    ITER_RUN  = 2'd1,
    ITER_DONE = 2'd2
  } iter_state_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/iter_counter_if.sv
// Control-unit <-> iteration-counter bundle. The master is the ALU control FSM,
// the slave is iter_counter.
interface iter_counter_if #(
  parameter int WIDTH = alu_pkg::ITER_W
);
  logic             start;
  logic             step;
  logic             abort;
  logic             dir;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] count;
  logic             at_term;
  logic             busy;
  logic             done;

  modport master (
    output start, step, abort, dir, start_val, term_val,
    input  count, at_term, busy, done
  );

  modport slave (
    input  start, step, abort, dir, start_val, term_val,
    output count, at_term, busy, done
  );
endinterface

// File: rtl/iter_counter.sv
// Programmable up/down iteration counter with start/busy/done handshake and
// abort, sequencing multi-cycle shift-add multiply and restoring divide.
module iter_counter
  import alu_pkg::*;
#(
  parameter int               WIDTH     = ITER_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_b,
  iter_counter_if.slave       bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  iter_state_e      state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] count_step;

  // Modular +/-1: wrap falls out of the fixed register width.
  assign count_step = (dir_q == DIR_DN) ? (count_q - ONE) : (count_q + ONE);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d  = term_q;
    dir_d   = dir_q;
    if (bus.start) begin
      count_d = bus.start_val;
      term_d  = bus.term_val;
      dir_d   = bus.dir;
      state_d = (bus.start_val == bus.term_val) ? ITER_DONE : ITER_RUN;
    end else begin
      case (state_q)
        ITER_RUN: begin
          if (bus.abort) begin
            state_d = ITER_IDLE;
          end else if (bus.step) begin
            count_d = count_step;
            if (count_step == term_q) begin
              state_d = ITER_DONE;
            end
          end
        end
        ITER_DONE: state_d = ITER_IDLE;
        ITER_IDLE: state_d = ITER_IDLE;
        default:   state_d = ITER_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= ITER_IDLE;
      count_q <= RESET_VAL;
      term_q  <= '0;
      dir_q   <= DIR_UP;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q  <= term_d;
      dir_q   <= dir_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.busy    = (state_q == ITER_RUN);
  assign bus.done    = (state_q == ITER_DONE);
  assign bus.at_term = (count_q == term_q);

endmodule
